// File: rtl/seqdet_sched.sv
// Word-to-serial scheduler feeding an overlapping pattern matcher.
// It also keeps a saturating match counter and a sticky threshold interrupt.
module seqdet_sched #(
    parameter int               WORD_W  = 8,
    parameter int               PAT_W   = 5,
    parameter logic [PAT_W-1:0] PATTERN = 5'b10010,
    parameter int               CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              pat_load,
    input  logic [PAT_W-1:0]  pat_in,
    input  logic [CNT_W-1:0]  thresh,
    input  logic              irq_clr,
    output logic              bit_out,
    output logic              bit_valid,
    output logic              hit,
    output logic [CNT_W-1:0]  match_cnt,
    output logic              irq,
    output logic              busy
);

    localparam int IDX_W  = $clog2(WORD_W);
    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(WORD_W - 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t              state_reg, state_next;
    logic [WORD_W-1:0]   shifter_reg, shifter_next;
    logic [IDX_W-1:0]    idx_reg, idx_next;
    logic [PAT_W-1:0]    pattern_reg, pattern_next;
    logic [PAT_W-1:0]    history_reg, history_next;
    logic [FILL_W-1:0]   fill_reg, fill_next;
    logic                hit_reg, hit_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic                irq_reg, irq_next;

    logic                last_bit;
    logic [PAT_W-1:0]    hist_shift;
    logic [PAT_W-1:0]    bit_eq;
    logic [FILL_W-1:0]   fill_inc;
    logic [CNT_W-1:0]    cnt_inc;

    assign bit_valid = (state_reg == SHIFT);
    assign busy      = bit_valid;
    assign bit_out   = bit_valid & shifter_reg[WORD_W-1];
    assign last_bit  = bit_valid && (idx_reg == LAST_IDX);
    assign s_ready   = (state_reg == IDLE) || last_bit;
    assign hit       = hit_reg;
    assign match_cnt = cnt_reg;
    assign irq       = irq_reg;

    // Candidate history after this edge, compared bitwise against the pattern.
    assign hist_shift = {history_reg[PAT_W-2:0], bit_out};
    assign fill_inc   = (fill_reg == FILL_FULL) ? FILL_FULL : fill_reg + FILL_W'(1);
    assign cnt_inc    = cnt_reg + CNT_W'(1);

    genvar gi;
    generate
        for (gi = 0; gi < PAT_W; gi++) begin : g_eq
            assign bit_eq[gi] = ~(hist_shift[gi] ^ pattern_reg[gi]);
        end
    endgenerate

    always_comb begin
        state_next   = state_reg;
        shifter_next = shifter_reg;
        idx_next     = idx_reg;
        pattern_next = pattern_reg;
        history_next = history_reg;
        fill_next    = fill_reg;
        hit_next     = 1'b0;
        cnt_next     = cnt_reg;
        irq_next     = irq_reg;

        case (state_reg)
            IDLE: begin
                if (s_valid) begin
                    shifter_next = s_data;
                    idx_next     = '0;
                    state_next   = SHIFT;
                end
                if (pat_load) begin
                    pattern_next = pat_in;
                    history_next = '0;
                    fill_next    = '0;
                end
            end
            SHIFT: begin
                shifter_next = shifter_reg << 1;
                idx_next     = idx_reg + IDX_W'(1);
                if (last_bit) begin
                    idx_next = '0;
                    if (s_valid) begin
                        shifter_next = s_data;
                    end else begin
                        state_next = IDLE;
                    end
                end
                history_next = hist_shift;
                fill_next    = fill_inc;
                hit_next     = (&bit_eq) && (fill_inc == FILL_FULL);
            end
            default: state_next = IDLE;
        endcase

        // Clear has priority over a coincident hit.
        if (irq_clr) begin
            cnt_next = '0;
            irq_next = 1'b0;
        end else if (hit_reg && (cnt_reg != CNT_MAX)) begin
            cnt_next = cnt_inc;
            if ((thresh != '0) && (cnt_inc == thresh)) begin
                irq_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            shifter_reg <= '0;
            idx_reg     <= '0;
            pattern_reg <= PATTERN;
            history_reg <= '0;
            fill_reg    <= '0;
            hit_reg     <= 1'b0;
            cnt_reg     <= '0;
            irq_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            shifter_reg <= shifter_next;
            idx_reg     <= idx_next;
            pattern_reg <= pattern_next;
            history_reg <= history_next;
            fill_reg    <= fill_next;
            hit_reg     <= hit_next;
            cnt_reg     <= cnt_next;
            irq_reg     <= irq_next;
        end
    end

endmodule
